ad7606_par_reader: RTL and testbench
====================================

Name: ad7606_par_reader

Overview:
Parametrised parallel-interface controller for AD7606-family ADCs, the successor to the fixed 8-channel driver.
- Runs the chip power-up reset, then the CONVST/BUSY handshake, then CS/RD readout of CH_NUM channels.
- Emits samples as a single stream tagged with channel index and last flag, instead of per-channel ports.
- Supports single-shot trigger and continuous sampling at a programmable period, with BUSY timeout recovery.
- Sits between the ADC pins and the acquisition/DMA logic.

Parameters:
CH_NUM, 8, channels read per conversion (1..8)
DATA_W, 16, ADC data bus width
T_RESET, 10, o_ad_reset high width in clocks (>=1)
T_CONV, 4, o_ad_convst low width in clocks (>=1)
T_RD_LO, 2, o_ad_rd_n low clocks per channel (>=1)
T_RD_HI, 2, o_ad_rd_n high clocks between channels (>=1)
BUSY_TO, 4096, max clocks waited for each BUSY edge
SAMPLE_PERIOD, 2000, continuous-mode conversion period in clocks

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  single-conversion request, sampled only in IDLE
i_cont_en  in  1  continuous mode enable
i_os  in  3  oversampling select; latched to o_ad_os on entry to CONV
o_busy  out  1  high in any state other than IDLE
o_data  out  DATA_W  captured sample
o_ch  out  3  channel index of o_data
o_valid  out  1  one-clock strobe per sample
o_last  out  1  with o_valid on channel CH_NUM-1
o_err  out  1  one-clock strobe on BUSY timeout
o_ad_os  out  3  ADC OS[2:0]
o_ad_reset  out  1  ADC RESET, active high
o_ad_convst  out  1  ADC CONVST A and B, idle high
o_ad_cs_n  out  1  ADC CS, active low
o_ad_rd_n  out  1  ADC RD, active low
i_ad_busy  in  1  ADC BUSY, asynchronous
i_ad_data  in  DATA_W  ADC DB bus

Behaviour:
- Asynchronous reset while i_rst_n=0: all FSM state cleared and outputs forced:
  - o_ad_reset=0, o_ad_convst=1, o_ad_cs_n=1, o_ad_rd_n=1, o_ad_os=0
  - o_data=0, o_ch=0, o_valid=0, o_last=0, o_err=0, o_busy=0
- Reset mid-operation aborts any conversion or readout immediately; no partial stream completion.
- All ADC-pin outputs are registered.
- i_ad_busy passes through a 2-FF synchroniser; all BUSY decisions use the synchronised copy.
- FSM states: ARST, IDLE, CONV, WAIT_BH, WAIT_BL, RD_LO, RD_HI.
- ARST (entered after reset release):
  - o_ad_reset=1 for exactly T_RESET clocks, then IDLE.
- IDLE:
  - Start condition: i_start=1, or i_cont_en=1 with period counter >= SAMPLE_PERIOD-1.
  - On start: go to CONV and latch i_os into o_ad_os.
  - Simultaneous start sources produce one conversion.
- CONV:
  - o_ad_convst=0 for exactly T_CONV clocks, then 1; go to WAIT_BH.
- WAIT_BH / WAIT_BL:
  - Wait for synchronised BUSY high, then low.
  - Each wait has its own counter; reaching BUSY_TO clocks pulses o_err for 1 clock and jumps to ARST (ADC is re-reset).
- RD_LO / RD_HI (channel counter starts at 0):
  - o_ad_cs_n=0 throughout readout.
  - o_ad_rd_n=0 for T_RD_LO clocks, then 1 for T_RD_HI clocks.
  - i_ad_data is captured on the edge where o_ad_rd_n returns high.
  - o_data/o_ch are updated and o_valid pulses on the following clock.
  - After channel CH_NUM-1's RD_HI: o_ad_cs_n=1, return to IDLE; o_last accompanies the final o_valid.
- o_data and o_ch hold their last value between strobes.
- Period counter:
  - Free-running, 32-bit, saturating; cleared on every CONV entry.
  - If a continuous start is due while not in IDLE, it fires on return to IDLE; no queueing beyond one.
- i_start asserted outside IDLE is ignored.
- Deasserting i_cont_en mid-conversion lets the current readout finish.
- Conversion length (clocks) = T_CONV + BUSY time + CH_NUM*(T_RD_LO+T_RD_HI).
- SAMPLE_PERIOD smaller than the conversion length degrades to back-to-back conversions.

Optional Feature:
AD7606_FRSTDATA_CHK_EN
- Defined:
  - Adds input i_ad_frstdata (1, ADC FRSTDATA) and output o_frst_err (1).
  - i_ad_frstdata is sampled with each data capture; expected 1 for channel 0 and 0 otherwise.
  - Mismatch pulses o_frst_err with that sample's o_valid; readout continues unchanged.
- Undefined: both ports absent; no check logic.

Test Plan:
1. Release reset -> o_ad_reset high exactly 10 clocks, then o_busy=0, o_ad_convst=1.
2. i_start pulse; BUSY model high 3 clocks after CONVST rise, low 50 clocks later; data=0x1000+ch -> 8 strobes, o_data 0x1000..0x1007, o_ch 0..7, o_last only with 0x1007, o_ad_cs_n low only during reads.
3. CH_NUM=3, i_cont_en=1, SAMPLE_PERIOD=500 -> CONVST falling edges exactly 500 clocks apart; 3 samples per conversion.
4. BUSY held low -> o_err pulses once 4096 clocks after the CONV exit clock, o_ad_reset reasserts for 10 clocks, FSM back in IDLE.
5. Assert i_rst_n=0 during RD_LO of channel 4 -> same cycle o_ad_rd_n=1, o_ad_cs_n=1, o_valid=0; no further strobes.
6. With AD7606_FRSTDATA_CHK_EN: FRSTDATA=1 on channel 2 -> o_frst_err pulse with the channel 2 strobe (and with channel 0 if it was low there).

Source files
------------

// File: rtl/ad7606_par_reader_if.sv
// ADC pin bundle plus the tagged sample stream of the AD7606 parallel reader.
// master = controller side, slave = ADC/consumer side.
interface ad7606_par_reader_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] o_data;
   logic [2:0]        o_ch;
   logic              o_valid;
   logic              o_last;
   logic [2:0]        o_ad_os;
   logic              o_ad_reset;
   logic              o_ad_convst;
   logic              o_ad_cs_n;
   logic              o_ad_rd_n;
   logic              i_ad_busy;
   logic [DATA_W-1:0] i_ad_data;

   modport master (
      output o_data, o_ch, o_valid, o_last,
      output o_ad_os, o_ad_reset, o_ad_convst, o_ad_cs_n, o_ad_rd_n,
      input  i_ad_busy, i_ad_data
   );

   modport slave (
      input  o_data, o_ch, o_valid, o_last,
      input  o_ad_os, o_ad_reset, o_ad_convst, o_ad_cs_n, o_ad_rd_n,
      output i_ad_busy, i_ad_data
   );
endinterface

// File: rtl/ad7606_par_reader.sv
// AD7606 parallel controller: chip reset, CONVST/BUSY handshake, CS/RD readout of CH_NUM channels into a tagged stream.
// Optional FRSTDATA consistency check is enabled by defining AD7606_FRSTDATA_CHK_EN.
module ad7606_par_reader #(
   parameter int CH_NUM        = 8,
   parameter int DATA_W        = 16,
   parameter int T_RESET       = 10,
   parameter int T_CONV        = 4,
   parameter int T_RD_LO       = 2,
   parameter int T_RD_HI       = 2,
   parameter int BUSY_TO       = 4096,
   parameter int SAMPLE_PERIOD = 2000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_cont_en,
   input  logic [2:0] i_os,
   output logic       o_busy,
   output logic       o_err,
   ad7606_par_reader_if.master bus
`ifdef AD7606_FRSTDATA_CHK_EN
   ,
   input  logic       i_ad_frstdata,
   output logic       o_frst_err
`endif
);
   typedef enum logic [2:0] {ARST, IDLE, CONV, WAIT_BH, WAIT_BL, RD_LO, RD_HI} state_t;

   localparam logic [31:0] RST_END  = 32'(T_RESET);
   localparam logic [31:0] CONV_END = 32'(T_CONV - 1);
   localparam logic [31:0] RDL_END  = 32'(T_RD_LO - 1);
   localparam logic [31:0] RDH_END  = 32'(T_RD_HI - 1);
   localparam logic [31:0] TO_END   = 32'(BUSY_TO - 1);
   localparam logic [31:0] PER_END  = 32'(SAMPLE_PERIOD - 1);
   localparam logic [2:0]  CH_LAST  = 3'(CH_NUM - 1);

   state_t            state;
   logic [31:0]       cnt;
   logic [31:0]       period;
   logic [2:0]        ch;
   logic              busy_s1, busy_s2;
   logic              cap_pend, cap_last;
   logic [2:0]        cap_ch;
   logic [DATA_W-1:0] cap_dat;
`ifdef AD7606_FRSTDATA_CHK_EN
   logic              cap_frst_bad;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state           <= ARST;
         cnt             <= '0;
         period          <= '0;
         ch              <= '0;
         busy_s1         <= 1'b0;
         busy_s2         <= 1'b0;
         cap_pend        <= 1'b0;
         cap_last        <= 1'b0;
         cap_ch          <= '0;
         cap_dat         <= '0;
         o_busy          <= 1'b0;
         o_err           <= 1'b0;
         bus.o_data      <= '0;
         bus.o_ch        <= '0;
         bus.o_valid     <= 1'b0;
         bus.o_last      <= 1'b0;
         bus.o_ad_os     <= '0;
         bus.o_ad_reset  <= 1'b0;
         bus.o_ad_convst <= 1'b1;
         bus.o_ad_cs_n   <= 1'b1;
         bus.o_ad_rd_n   <= 1'b1;
`ifdef AD7606_FRSTDATA_CHK_EN
         cap_frst_bad    <= 1'b0;
         o_frst_err      <= 1'b0;
`endif
      end else begin
         busy_s1     <= bus.i_ad_busy;
         busy_s2     <= busy_s1;
         o_err       <= 1'b0;
         bus.o_valid <= 1'b0;
         bus.o_last  <= 1'b0;
         cap_pend    <= 1'b0;
         if (period != '1)
            period <= period + 32'd1;
         // Sample captured on the RD rising edge is published one clock later.
         if (cap_pend) begin
            bus.o_valid <= 1'b1;
            bus.o_data  <= cap_dat;
            bus.o_ch    <= cap_ch;
            bus.o_last  <= cap_last;
         end
`ifdef AD7606_FRSTDATA_CHK_EN
         o_frst_err <= cap_pend && cap_frst_bad;
`endif
         case (state)
            ARST: begin
               bus.o_ad_reset <= 1'b1;
               o_busy         <= 1'b1;
               cnt            <= cnt + 32'd1;
               if (cnt == RST_END) begin
                  bus.o_ad_reset <= 1'b0;
                  o_busy         <= 1'b0;
                  cnt            <= '0;
                  state          <= IDLE;
               end
            end
            IDLE: begin
               if (i_start || (i_cont_en && period >= PER_END)) begin
                  bus.o_ad_os     <= i_os;
                  bus.o_ad_convst <= 1'b0;
                  o_busy          <= 1'b1;
                  period          <= '0;
                  cnt             <= '0;
                  state           <= CONV;
               end
            end
            CONV: begin
               cnt <= cnt + 32'd1;
               if (cnt == CONV_END) begin
                  bus.o_ad_convst <= 1'b1;
                  cnt             <= '0;
                  state           <= WAIT_BH;
               end
            end
            WAIT_BH, WAIT_BL: begin
               cnt <= cnt + 32'd1;
               if (state == WAIT_BH && busy_s2) begin
                  cnt   <= '0;
                  state <= WAIT_BL;
               end else if (state == WAIT_BL && !busy_s2) begin
                  bus.o_ad_cs_n <= 1'b0;
                  bus.o_ad_rd_n <= 1'b0;
                  ch            <= '0;
                  cnt           <= '0;
                  state         <= RD_LO;
               end else if (cnt == TO_END) begin
                  // A stuck BUSY means the ADC is in an unknown state: re-reset it.
                  o_err <= 1'b1;
                  cnt   <= '0;
                  state <= ARST;
               end
            end
            RD_LO: begin
               cnt <= cnt + 32'd1;
               if (cnt == RDL_END) begin
                  bus.o_ad_rd_n <= 1'b1;
                  cap_pend      <= 1'b1;
                  cap_dat       <= bus.i_ad_data;
                  cap_ch        <= ch;
                  cap_last      <= (ch == CH_LAST);
`ifdef AD7606_FRSTDATA_CHK_EN
                  cap_frst_bad  <= (i_ad_frstdata != (ch == 3'd0));
`endif
                  cnt           <= '0;
                  state         <= RD_HI;
               end
            end
            RD_HI: begin
               cnt <= cnt + 32'd1;
               if (cnt == RDH_END) begin
                  cnt <= '0;
                  if (ch == CH_LAST) begin
                     bus.o_ad_cs_n <= 1'b1;
                     o_busy        <= 1'b0;
                     state         <= IDLE;
                  end else begin
                     ch            <= ch + 3'd1;
                     bus.o_ad_rd_n <= 1'b0;
                     state         <= RD_LO;
                  end
               end
            end
            default: state <= ARST;
         endcase
      end
   end
endmodule

// File: tb/tb_ad7606_par_reader.sv
// Directed bench: instance a (8 channels) for reset, readout, start-ignore, timeout and mid-read reset;
// instance b (3 channels, period 500) for continuous sampling.
module tb_ad7606_par_reader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   logic       start_a = 0, cont_a = 0, busy_a, err_a;
   logic [2:0] os_a = 0;
   logic       start_b = 0, cont_b = 0, busy_b, err_b;
   logic [2:0] os_b = 0;
   ad7606_par_reader_if bus_a ();
   ad7606_par_reader_if bus_b ();
`ifdef AD7606_FRSTDATA_CHK_EN
   logic frst_a = 1'b0, frst_err_a, frst_b = 1'b0, frst_err_b;
   int   frst_cnt_a = 0;
`endif

   ad7606_par_reader dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_cont_en(cont_a), .i_os(os_a),
      .o_busy(busy_a), .o_err(err_a), .bus(bus_a.master)
`ifdef AD7606_FRSTDATA_CHK_EN
      , .i_ad_frstdata(frst_a), .o_frst_err(frst_err_a)
`endif
   );

   ad7606_par_reader #(.CH_NUM(3), .SAMPLE_PERIOD(500)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_cont_en(cont_b), .i_os(os_b),
      .o_busy(busy_b), .o_err(err_b), .bus(bus_b.master)
`ifdef AD7606_FRSTDATA_CHK_EN
      , .i_ad_frstdata(frst_b), .o_frst_err(frst_err_b)
`endif
   );

   // ADC models: data = base + number of completed reads in this CS window.
   logic [15:0] base_a = 16'h1000;
   int   rdc_a = 0, rdc_b = 0;
   logic prev_rd_a = 1'b1, prev_rd_b = 1'b1, prev_cv_a = 1'b1, prev_cv_b = 1'b1;
   logic busy_en_a = 1'b1;
   int   rst_hi_a = 0, cs_lo_a = 0, rd_lo_a = 0, viol_a = 0, vn_a = 0, last_a = 0;
   int   err_cnt_a = 0, err_cyc_a = 0, rise_cyc_a = 0;
   logic [15:0] vd_a [8];
   logic [2:0]  vc_a [8];
   logic        vl_a [8];
   int   fall_b [8];
   int   nf_b = 0, vn_b = 0, last_b = 0;

   always @(negedge clk) begin
      if (bus_a.o_ad_cs_n) rdc_a = 0;
      else if (bus_a.o_ad_rd_n && !prev_rd_a) rdc_a++;
      prev_rd_a = bus_a.o_ad_rd_n;
      bus_a.i_ad_data = base_a + 16'(rdc_a);
`ifdef AD7606_FRSTDATA_CHK_EN
      frst_a = (rdc_a == 2);
      if (frst_err_a) frst_cnt_a++;
`endif
      if (bus_a.o_ad_reset) rst_hi_a++;
      if (!bus_a.o_ad_cs_n) cs_lo_a++;
      if (!bus_a.o_ad_rd_n) rd_lo_a++;
      if (!bus_a.o_ad_rd_n && bus_a.o_ad_cs_n) viol_a++;
      if (bus_a.o_valid) begin
         if (vn_a < 8) begin
            vd_a[vn_a] = bus_a.o_data;
            vc_a[vn_a] = bus_a.o_ch;
            vl_a[vn_a] = bus_a.o_last;
         end
         vn_a++;
      end
      if (bus_a.o_last) last_a++;
      if (err_a) begin
         err_cnt_a++;
         err_cyc_a = cyc;
      end
      if (bus_a.o_ad_convst && !prev_cv_a) rise_cyc_a = cyc;
      prev_cv_a = bus_a.o_ad_convst;

      if (bus_b.o_ad_cs_n) rdc_b = 0;
      else if (bus_b.o_ad_rd_n && !prev_rd_b) rdc_b++;
      prev_rd_b = bus_b.o_ad_rd_n;
      bus_b.i_ad_data = 16'h2000 + 16'(rdc_b);
`ifdef AD7606_FRSTDATA_CHK_EN
      frst_b = (rdc_b == 0);
`endif
      if (!bus_b.o_ad_convst && prev_cv_b) begin
         if (nf_b < 8) fall_b[nf_b] = cyc;
         nf_b++;
      end
      prev_cv_b = bus_b.o_ad_convst;
      if (bus_b.o_valid) vn_b++;
      if (bus_b.o_last) last_b++;
   end

   // BUSY: high 3 clocks after CONVST rises, low again 50 clocks later.
   initial begin
      bus_a.i_ad_busy = 1'b0;
      forever begin
         @(posedge bus_a.o_ad_convst);
         if (busy_en_a && rst_n) begin
            repeat (3) @(posedge clk);
            #1 bus_a.i_ad_busy = 1'b1;
            repeat (50) @(posedge clk);
            #1 bus_a.i_ad_busy = 1'b0;
         end
      end
   end

   initial begin
      bus_b.i_ad_busy = 1'b0;
      forever begin
         @(posedge bus_b.o_ad_convst);
         if (rst_n) begin
            repeat (3) @(posedge clk);
            #1 bus_b.i_ad_busy = 1'b1;
            repeat (50) @(posedge clk);
            #1 bus_b.i_ad_busy = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [15:0] pat_base [2];
   logic [2:0]  pat_os [2];

   initial begin
      pat_base[0] = 16'h1000; pat_os[0] = 3'd5;
      pat_base[1] = 16'hA5F0; pat_os[1] = 3'd2;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_convst", 32'(bus_a.o_ad_convst), 1);
      check("rst_cs_n", 32'(bus_a.o_ad_cs_n), 1);
      check("rst_rd_n", 32'(bus_a.o_ad_rd_n), 1);
      check("rst_adreset", 32'(bus_a.o_ad_reset), 0);
      check("rst_os", 32'(bus_a.o_ad_os), 0);
      check("rst_data", 32'(bus_a.o_data), 0);
      check("rst_ch", 32'(bus_a.o_ch), 0);
      check("rst_valid", 32'(bus_a.o_valid), 0);
      check("rst_busy", 32'(busy_a), 0);
      check("rst_err", 32'(err_a), 0);

      // Power-up reset pulse width
      rst_hi_a = 0;
      @(negedge clk) rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("pwrup_reset_width", 32'(rst_hi_a), 10);
      check("pwrup_busy", 32'(busy_a), 0);
      check("pwrup_convst", 32'(bus_a.o_ad_convst), 1);

      // Single-shot readout, two data patterns; a start during the conversion is ignored
      for (int p = 0; p < 2; p++) begin
         base_a = pat_base[p];
         vn_a = 0; last_a = 0; cs_lo_a = 0; rd_lo_a = 0; viol_a = 0;
`ifdef AD7606_FRSTDATA_CHK_EN
         frst_cnt_a = 0;
`endif
         os_a = pat_os[p];
         @(negedge clk) start_a = 1'b1;
         @(negedge clk) start_a = 1'b0;
         os_a = 3'd0;
         repeat (20) @(negedge clk);
         start_a = 1'b1;
         @(negedge clk) start_a = 1'b0;
         for (int i = 0; i < 400 && vn_a < 8; i++) @(negedge clk);
         repeat (150) @(negedge clk);
         check("strobe_count", 32'(vn_a), 8);
         for (int i = 0; i < 8; i++) begin
            check("sample_data", 32'(vd_a[i]), 32'(pat_base[p]) + 32'(i));
            check("sample_ch", 32'(vc_a[i]), 32'(i));
            check("sample_last", 32'(vl_a[i]), (i == 7) ? 32'd1 : 32'd0);
         end
         check("last_count", 32'(last_a), 1);
         check("cs_low_clocks", 32'(cs_lo_a), 32);
         check("rd_low_clocks", 32'(rd_lo_a), 16);
         check("rd_outside_cs", 32'(viol_a), 0);
         check("os_latched", 32'(bus_a.o_ad_os), 32'(pat_os[p]));
         check("busy_after", 32'(busy_a), 0);
         check("data_held", 32'(bus_a.o_data), 32'(pat_base[p]) + 32'd7);
`ifdef AD7606_FRSTDATA_CHK_EN
         check("frst_err_count", 32'(frst_cnt_a), 2);
`endif
      end

      // BUSY never rises: timeout, ADC re-reset, back to IDLE
      busy_en_a = 1'b0;
      err_cnt_a = 0; rst_hi_a = 0; vn_a = 0;
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      for (int i = 0; i < 5000 && err_cnt_a == 0; i++) @(negedge clk);
      check("timeout_seen", 32'(err_cnt_a), 1);
      check("timeout_delay", 32'(err_cyc_a - rise_cyc_a), 4096);
      repeat (30) @(negedge clk);
      check("timeout_single_pulse", 32'(err_cnt_a), 1);
      check("timeout_rereset_width", 32'(rst_hi_a), 10);
      check("timeout_idle", 32'(busy_a), 0);
      check("timeout_no_strobe", 32'(vn_a), 0);
      busy_en_a = 1'b1;

      // Continuous mode on the 3-channel instance
      nf_b = 0; vn_b = 0; last_b = 0;
      @(negedge clk) cont_b = 1'b1;
      for (int i = 0; i < 2500 && nf_b < 4; i++) @(negedge clk);
      check("cont_fall_count", 32'(nf_b), 4);
      check("cont_period_1", 32'(fall_b[1] - fall_b[0]), 500);
      check("cont_period_2", 32'(fall_b[2] - fall_b[1]), 500);
      check("cont_period_3", 32'(fall_b[3] - fall_b[2]), 500);
      check("cont_samples", 32'(vn_b), 9);
      check("cont_lasts", 32'(last_b), 3);
      cont_b = 1'b0;
      repeat (150) @(negedge clk);
      check("cont_stop_finishes", 32'(vn_b), 12);

      // Reset during RD_LO of channel 4 aborts the readout
      vn_a = 0;
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      for (int i = 0; i < 400 && !(rdc_a == 4 && !bus_a.o_ad_rd_n && !bus_a.o_ad_cs_n); i++)
         @(negedge clk);
      check("abort_reached_ch4", 32'(rdc_a), 4);
      check("abort_strobes_before", 32'(vn_a), 4);
      #1 rst_n = 1'b0;
      #1;
      check("abort_rd_n", 32'(bus_a.o_ad_rd_n), 1);
      check("abort_cs_n", 32'(bus_a.o_ad_cs_n), 1);
      check("abort_valid", 32'(bus_a.o_valid), 0);
      check("abort_busy", 32'(busy_a), 0);
      repeat (3) @(negedge clk);
      rst_hi_a = 0;
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("abort_no_more_strobes", 32'(vn_a), 4);
      check("abort_rereset_width", 32'(rst_hi_a), 10);
      check("abort_idle", 32'(busy_a), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
